// File: rtl/data_mem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM encodings and the abort read value.
package data_mem_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] MEM_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_mem_bridge.sv
// CPU data-port to req/ack bus bridge; stalls the core until the RAM acknowledges.
// Optional REQ-phase timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  cpu_rst_n,
  input  logic                  req_ren,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_err,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [1:0] state;
  logic       take;
  logic       tmo_hit;
  logic       unused_bits;

  assign take  = (state == ST_IDLE) && (req_ren || req_wen);
  assign stall = take || (state == ST_REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter loaded on entry to REQ; terminal count with no ack aborts.
  assign tmo_hit = (state == ST_REQ) && !bus_ack && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      if (take) begin
        tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      end else if ((state == ST_REQ) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
      if (tmo_hit) begin
        bus_err <= 1'b1;
      end
    end
  end

  assign unused_bits = ^req_addr[1:0];
`else
  assign tmo_hit     = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_bits = ^{req_addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_din   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state     <= ST_REQ;
            bus_req   <= 1'b1;
            bus_we    <= req_wen;
            bus_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata <= req_wdata;
          end
        end
        ST_REQ: begin
          // An ack arriving on the terminal-count cycle still completes normally.
          if (bus_ack) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              mem_din <= bus_rdata;
            end
          end else if (tmo_hit) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            mem_din <= DATA_WIDTH'(MEM_ABORT_DATA);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: the driver queues expected commits, a monitor checks them.
module tb_data_mem_bridge;

  logic        clk;
  logic        cpu_rst_n;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_din;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [31:0] din;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  data_mem_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4),
    .CNT_WIDTH     (16)
  ) dut (
    .clk      (clk),
    .cpu_rst_n(cpu_rst_n),
    .req_ren  (req_ren),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .mem_din  (mem_din),
    .stall    (stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .bus_err  (bus_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Commit monitor: the DONE cycle is the first cycle after bus_req falls outside reset.
  logic prev_req = 1'b0;
  int   stall_run = 0;
  always @(negedge clk) begin
    if (!cpu_rst_n) begin
      prev_req  = 1'b0;
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (prev_req && !bus_req) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL commit_unexpected: got commit mem_din %h expected no commit", mem_din);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("commit_mem_din", mem_din, e.din);
          chk("commit_stall", {31'b0, stall}, 32'd0);
          chk("commit_stall_cycles", stall_run, e.stalls);
        end
        stall_run = 0;
      end
      prev_req = bus_req;
    end
  end

  task automatic txn(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int w, input logic [31:0] exp_din);
    exp_t e;
    logic [31:0] exp_addr;
    e.din    = exp_din;
    e.stalls = w + 2;
    q.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wdata;
    #1 chk("stall_take", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    req_ren = 1'b0; req_wen = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    chk("bus_req_high", {31'b0, bus_req}, 32'd1);
    chk("bus_addr", bus_addr, exp_addr);
    chk("bus_we", {31'b0, bus_we}, {31'b0, wen});
    if (wen) chk("bus_wdata", bus_wdata, wdata);
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
    end
    chk("bus_req_held", {31'b0, bus_req}, 32'd1);
    chk("bus_addr_held", bus_addr, exp_addr);
    bus_ack = 1'b1; bus_rdata = rdata;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expired expected run complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst_n = 1'b0;
    req_ren = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    cpu_rst_n = 1'b1;

    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 32'h1234_5678);
    chk("stall_cnt_first", {16'b0, stall_cnt}, 32'd3);
    txn(1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'hBAD0_BAD0, 2, 32'h1234_5678);

    // Stray ack while idle must not move data or start a request.
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("stray_ack_mem_din", mem_din, 32'h1234_5678);
    chk("stray_ack_bus_req", {31'b0, bus_req}, 32'd0);

    txn(1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'hA5A5_0001, 0, 32'hA5A5_0001);
    txn(1'b1, 1'b0, 32'h0000_0208, 32'h0, 32'h5A5A_0002, 3, 32'h5A5A_0002);
    txn(1'b1, 1'b1, 32'h0000_0031, 32'h7777_8888, 32'hBAD0_0003, 0, 32'h5A5A_0002);
    chk("stall_cnt_sum", {16'b0, stall_cnt}, 32'd16);

    // Reset in the middle of REQ: bus_req drops at once, later ack is ignored.
    @(posedge clk); #1;
    req_ren = 1'b1; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    chk("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
    req_ren = 1'b0;
    cpu_rst_n = 1'b0;
    #1;
    chk("rst_async_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_async_stall", {31'b0, stall}, 32'd0);
    chk("rst_async_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    cpu_rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("post_rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_mem_din", mem_din, 32'd0);

    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_0000, 0, 32'hFFFF_0000);

`ifdef MEM_TIMEOUT_EN
    begin
      exp_t e;
      e.din = 32'hDEAD_BEEF;
      e.stalls = 5;
      q.push_back(e);
      @(posedge clk); #1;
      req_ren = 1'b1; req_addr = 32'h0000_0500;
      @(posedge clk); #1;
      req_ren = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (!bus_req) break;
        @(posedge clk); #1;
      end
      chk("timeout_bus_req", {31'b0, bus_req}, 32'd0);
      chk("timeout_mem_din", mem_din, 32'hDEAD_BEEF);
      chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
      txn(1'b1, 1'b0, 32'h0000_0504, 32'h0, 32'h1357_9BDF, 0, 32'h1357_9BDF);
      chk("bus_err_sticky", {31'b0, bus_err}, 32'd1);
    end
`else
    txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0F0F_0F0F, 70000, 32'h0F0F_0F0F);
    chk("stall_cnt_saturated", {16'b0, stall_cnt}, 32'h0000_FFFF);
    chk("bus_err_tied_low", {31'b0, bus_err}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
